// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between decode/register file and the HI/LO
// multiply/divide unit. The master drives requests and mthi/mtlo writes;
// the slave (the unit) returns status and the architectural HI/LO values.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Operands are converted to magnitudes at start, one result bit is produced
// per cycle for WIDTH cycles (shift-add multiply, restoring divide), and a
// final FIX cycle applies sign correction and commits HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, nextState;

    logic [CNT_W-1:0] iterCnt;
    logic [WIDTH-1:0] hiReg, loReg;
    logic             doneReg;

    // Operation context captured at start; data only, never reset.
    logic             isDiv, negRes, negRem, divZero;
    logic [WIDTH-1:0] rsRaw, bMag;
    logic [WIDTH-1:0] accHi, accLo;

    logic             opSigned, rsNeg, rtNeg, lastIter, accept;
    logic [WIDTH:0]   mulSum, divTrial;
    logic             divFits;
    logic [WIDTH-1:0] divRem, resHi, resLo;

    function automatic logic signed [WIDTH-1:0] negW(input logic signed [WIDTH-1:0] x);
        return -x;
    endfunction

    function automatic logic signed [2*WIDTH-1:0] neg2W(input logic signed [2*WIDTH-1:0] x);
        return -x;
    endfunction

    // Magnitude of a possibly-negative operand; -2^(W-1) maps to 2^(W-1) unsigned.
    function automatic logic [WIDTH-1:0] magW(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? negW(x) : x;
    endfunction

    assign opSigned = ~bus.op[0];
    assign rsNeg    = opSigned & bus.rs_data[WIDTH-1];
    assign rtNeg    = opSigned & bus.rt_data[WIDTH-1];
    assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));
    assign accept   = (state == IDLE) && bus.start;

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, bMag} : '0);
        divTrial = {accHi, accLo[WIDTH-1]};
        divFits  = (divTrial >= {1'b0, bMag});
        divRem   = divFits ? WIDTH'(divTrial - {1'b0, bMag}) : divTrial[WIDTH-1:0];
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        resHi = accHi;
        resLo = accLo;
        if (!isDiv) begin
            if (negRes) {resHi, resLo} = neg2W({accHi, accLo});
        end else if (divZero) begin
            resHi = rsRaw;
            resLo = '1;
        end else begin
            if (negRes) resLo = negW(accLo);
            if (negRem) resHi = negW(accHi);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = RUN;
            RUN:     if (lastIter)  nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Architectural HI/LO, iteration counter and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hiReg   <= '0;
            loReg   <= '0;
            iterCnt <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= (state == FIX);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        iterCnt <= '0;
                    end else begin
                        if (bus.hi_we) hiReg <= bus.wr_data;
                        if (bus.lo_we) loReg <= bus.wr_data;
                    end
                end
                RUN:     iterCnt <= iterCnt + 1'b1;
                FIX: begin
                    hiReg <= resHi;
                    loReg <= resLo;
                end
                default: ;
            endcase
        end
    end

    // Operand capture and per-cycle accumulator update.
    always_ff @(posedge clk) begin
        if (accept) begin
            isDiv   <= bus.op[1];
            negRes  <= rsNeg ^ rtNeg;
            negRem  <= rsNeg;
            divZero <= bus.op[1] && (bus.rt_data == '0);
            rsRaw   <= bus.rs_data;
            bMag    <= magW(bus.rt_data, rtNeg);
            accHi   <= '0;
            accLo   <= magW(bus.rs_data, rsNeg);
        end else if (state == RUN) begin
            if (isDiv) begin
                accHi <= divRem;
                accLo <= {accLo[WIDTH-2:0], divFits};
            end else begin
                accHi <= mulSum[WIDTH:1];
                accLo <= {mulSum[0], accLo[WIDTH-1:1]};
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = doneReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of operations with hand-computed
// HI/LO results, plus sequences for mthi/mtlo, busy-time interference and
// reset in the middle of an operation.
module tb_mult_div_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] expHi;
        logic [31:0] expLo;
        bit          wrOnStart;
        bit          disturb;
    } vec_t;

    vec_t vecs[13];

    int checks   = 0;
    int failures = 0;
    logic [31:0] curHi, curLo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic runOp(input vec_t v, input int idx);
        int lat;
        int nDone;
        lat   = -1;
        nDone = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = v.op;
        bus.rs_data = v.rs;
        bus.rt_data = v.rt;
        if (v.wrOnStart) begin
            bus.hi_we   = 1'b1;
            bus.lo_we   = 1'b1;
            bus.wr_data = 32'hBAD0BAD0;
        end
        @(posedge clk);
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.start   = 1'b0;
                bus.hi_we   = 1'b0;
                bus.lo_we   = 1'b0;
                bus.rs_data = ~v.rs;
                bus.rt_data = v.rt + 32'd1;
            end
            if (n == 1) begin
                check($sformatf("v%0d_busy_run", idx), {31'd0, bus.busy}, 32'd1);
                check($sformatf("v%0d_hi_hold", idx), bus.hi, curHi);
                check($sformatf("v%0d_lo_hold", idx), bus.lo, curLo);
            end
            if (v.disturb) begin
                if (n == 5 || n == 20) begin
                    bus.start   = 1'b1;
                    bus.op      = 2'b01;
                    bus.rs_data = 32'd3;
                    bus.rt_data = 32'd3;
                end
                if (n == 6 || n == 21) bus.start = 1'b0;
                if (n == 10) begin
                    bus.hi_we   = 1'b1;
                    bus.lo_we   = 1'b1;
                    bus.wr_data = 32'h0000DEAD;
                end
                if (n == 11) begin
                    bus.hi_we = 1'b0;
                    bus.lo_we = 1'b0;
                end
                if (n == 31) begin
                    check($sformatf("v%0d_hi_busywr", idx), bus.hi, curHi);
                    check($sformatf("v%0d_lo_busywr", idx), bus.lo, curLo);
                end
            end
            if (bus.done) begin
                nDone++;
                if (lat < 0) begin
                    lat = n;
                    check($sformatf("v%0d_busy_at_done", idx), {31'd0, bus.busy}, 32'd0);
                end
            end
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'd33);
        check($sformatf("v%0d_done_count", idx), 32'(nDone), 32'd1);
        check($sformatf("v%0d_hi", idx), bus.hi, v.expHi);
        check($sformatf("v%0d_lo", idx), bus.lo, v.expLo);
        curHi = v.expHi;
        curLo = v.expLo;
    endtask

    initial begin
        int nDone;
        //         op     rs            rt            expHi         expLo         wr  dist
        vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
        vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[3]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
        vecs[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
        vecs[6]  = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b1};
        vecs[7]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b1, 1'b0};
        vecs[8]  = '{2'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0};
        vecs[9]  = '{2'd2, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{2'd0, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0};
        vecs[11] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[12] = '{2'd3, 32'h000003E8, 32'h00000003, 32'h00000001, 32'h0000014D, 1'b0, 1'b0};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wr_data = '0;
        curHi       = '0;
        curLo       = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) runOp(vecs[i], i);

        // mthi then mtlo in IDLE, then both together
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wr_data = 32'h00001234;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wr_data = 32'h00005678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mthi_idle", bus.hi, 32'h00001234);
        check("mtlo_idle", bus.lo, 32'h00005678);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h0000ABCD;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mthilo_both_hi", bus.hi, 32'h0000ABCD);
        check("mthilo_both_lo", bus.lo, 32'h0000ABCD);
        curHi = 32'h0000ABCD;
        curLo = 32'h0000ABCD;

        for (int i = 5; i < 12; i++) runOp(vecs[i], i);

        // Reset in the middle of a DIVU run
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
        @(posedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 0) bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        curHi = '0;
        curLo = '0;
        nDone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) nDone++;
        end
        check("rst_mid_no_done", 32'(nDone), 32'd0);
        check("rst_mid_hi_after", bus.hi, 32'd0);
        runOp(vecs[12], 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
